// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one UART byte transmitter between NREQ byte
// streams, optionally locking the grant until a requester's packet is complete.
module uart_tx_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          LOCK_PKT     = 1,
    parameter logic [15:0] IDLE_TIMEOUT = 16'd50000,
    parameter logic [2:0]  BUSY_WAIT    = 3'd4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [8*NREQ-1:0]    req_data_i,
    input  logic [NREQ-1:0]      req_last_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_en_o,
    input  logic                 tx_busy_i,
    output logic                 active_o,
    output logic                 err_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        HOLD
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     rrPtr_q;
    logic [IW-1:0]     gIdx_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   ready_q;
    logic [7:0]        txData_q;
    logic              txEn_q;
    logic              err_q;
    logic              lock_q;
    logic [15:0]       idleCnt_q;
    logic [2:0]        busyCnt_q;

    logic              winValid_d;
    logic [IW-1:0]     winIdx_d;

    function automatic logic [IW-1:0] wrapIdx(input int k);
        return IW'((k >= NREQ) ? k - NREQ : k);
    endfunction

    function automatic logic [IW-1:0] nextPtr(input logic [IW-1:0] g);
        if (int'(g) == NREQ - 1) return '0;
        return g + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] oneHot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scanning downward lets the requester closest above rrPtr_q win last-write.
    always_comb begin
        winValid_d = 1'b0;
        winIdx_d   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[wrapIdx(int'(rrPtr_q) + i)]) begin
                winValid_d = 1'b1;
                winIdx_d   = wrapIdx(int'(rrPtr_q) + i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DRAIN;
            rrPtr_q   <= '0;
            gIdx_q    <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            txData_q  <= 8'h00;
            txEn_q    <= 1'b0;
            err_q     <= 1'b0;
            lock_q    <= 1'b0;
            idleCnt_q <= '0;
            busyCnt_q <= '0;
        end else begin
            txEn_q  <= 1'b0;
            ready_q <= '0;
            case (state_q)
                DRAIN: begin
                    if (!tx_busy_i) state_q <= IDLE;
                end
                IDLE: begin
                    if (winValid_d) begin
                        gIdx_q   <= winIdx_d;
                        grant_q  <= oneHot(winIdx_d);
                        ready_q  <= oneHot(winIdx_d);
                        txData_q <= req_data_i[8*winIdx_d +: 8];
                        txEn_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end else begin
                        grant_q <= '0;
                    end
                end
                ISSUE: begin
                    lock_q    <= (LOCK_PKT != 0) && !req_last_i[gIdx_q];
                    busyCnt_q <= 3'd1;
                    state_q   <= WAIT_HI;
                end
                // The tx_en cycle itself counts toward the busy-rise allowance.
                WAIT_HI: begin
                    if (tx_busy_i) begin
                        state_q <= WAIT_LO;
                    end else if (busyCnt_q + 3'd1 >= BUSY_WAIT) begin
                        err_q   <= 1'b1;
                        lock_q  <= 1'b0;
                        grant_q <= '0;
                        rrPtr_q <= nextPtr(gIdx_q);
                        state_q <= IDLE;
                    end else begin
                        busyCnt_q <= busyCnt_q + 3'd1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy_i) begin
                        if (lock_q && req_valid_i[gIdx_q]) begin
                            ready_q  <= grant_q;
                            txData_q <= req_data_i[8*gIdx_q +: 8];
                            txEn_q   <= 1'b1;
                            state_q  <= ISSUE;
                        end else if (lock_q) begin
                            idleCnt_q <= '0;
                            state_q   <= HOLD;
                        end else begin
                            grant_q <= '0;
                            rrPtr_q <= nextPtr(gIdx_q);
                            state_q <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (req_valid_i[gIdx_q]) begin
                        idleCnt_q <= '0;
                        ready_q   <= grant_q;
                        txData_q  <= req_data_i[8*gIdx_q +: 8];
                        txEn_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end else if (idleCnt_q == IDLE_TIMEOUT - 16'd1) begin
                        idleCnt_q <= '0;
                        lock_q    <= 1'b0;
                        grant_q   <= '0;
                        rrPtr_q   <= nextPtr(gIdx_q);
                        state_q   <= IDLE;
                    end else begin
                        idleCnt_q <= idleCnt_q + 16'd1;
                    end
                end
                default: state_q <= DRAIN;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign grant_o     = grant_q;
    assign tx_data_o   = txData_q;
    assign tx_en_o     = txEn_q;
    assign err_o       = err_q;
    assign active_o    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: queue-driven requesters, a simple transmitter model
// and a scoreboard of expected (owner, byte) pairs checked at every tx_en pulse.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int FRAME = 6;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqLast;
    logic [8*NREQ-1:0] reqData;
    logic modelBusy, forceBusy, deadTx, useAlt, startPending;
    logic txBusy;

    logic [NREQ-1:0] readyA, grantA, readyB, grantB;
    logic [7:0]      txDataA, txDataB;
    logic            txEnA, txEnB, activeA, activeB, errA, errB;

    logic [NREQ-1:0] selReady, selGrant;
    logic [7:0]      selTxData;
    logic            selTxEn, selActive, selErr;

    logic [8:0]      reqQ [NREQ][$];
    exp_t            expQ [$];
    logic [NREQ-1:0] popPending;
    logic [8:0]      headEntry;
    exp_t            monEntry;
    int              remaining;
    int              waitN;
    int              enCount;
    int              passCount = 0;
    int              checkCount = 0;
    int              failCount = 0;

    assign txBusy    = modelBusy | forceBusy;
    assign selReady  = useAlt ? readyB  : readyA;
    assign selGrant  = useAlt ? grantB  : grantA;
    assign selTxData = useAlt ? txDataB : txDataA;
    assign selTxEn   = useAlt ? txEnB   : txEnA;
    assign selActive = useAlt ? activeB : activeA;
    assign selErr    = useAlt ? errB    : errA;

    uart_tx_arbiter #(
        .NREQ(NREQ), .LOCK_PKT(1), .IDLE_TIMEOUT(16'd10), .BUSY_WAIT(3'd4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_data_i(reqData), .req_last_i(reqLast),
        .req_ready_o(readyA), .grant_o(grantA),
        .tx_data_o(txDataA), .tx_en_o(txEnA), .tx_busy_i(txBusy),
        .active_o(activeA), .err_o(errA)
    );

    uart_tx_arbiter #(
        .NREQ(NREQ), .LOCK_PKT(0), .IDLE_TIMEOUT(16'd10), .BUSY_WAIT(3'd4)
    ) dutNoLock (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_data_i(reqData), .req_last_i(reqLast),
        .req_ready_o(readyB), .grant_o(grantB),
        .tx_data_o(txDataB), .tx_en_o(txEnB), .tx_busy_i(txBusy),
        .active_o(activeB), .err_o(errB)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (failure #%0d)",
                   tag, observed, expected, failCount);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] data, input logic last);
        reqQ[k].push_back({last, data});
    endtask

    task automatic expectTx(input logic [1:0] idx, input logic [7:0] data);
        expQ.push_back('{idx: idx, data: data});
    endtask

    task automatic waitQuiet(input string tag);
        int  n = 0;
        logic quiet = 1'b0;
        while (!quiet && n < 400) begin
            @(negedge clk);
            n++;
            quiet = (expQ.size() == 0) && !selActive && !txBusy && !selTxEn && (reqValid == '0);
        end
        checkOutput(tag, 32'(quiet), 32'd1);
    endtask

    task automatic waitTxEn(input string tag);
        int n = 0;
        while (!selTxEn && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(selTxEn), 32'd1);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // A byte is popped one negedge after ready is seen, so it stays stable through ISSUE.
    initial begin
        reqValid   = '0;
        reqData    = '0;
        reqLast    = '0;
        popPending = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                if (popPending[k] && reqQ[k].size() > 0) void'(reqQ[k].pop_front());
                popPending[k] = selReady[k];
                if (reqQ[k].size() > 0) begin
                    headEntry          = reqQ[k][0];
                    reqValid[k]        = 1'b1;
                    reqData[8*k +: 8]  = headEntry[7:0];
                    reqLast[k]         = headEntry[8];
                end else begin
                    reqValid[k] = 1'b0;
                    reqLast[k]  = 1'b0;
                end
            end
        end
    end

    initial begin
        modelBusy    = 1'b0;
        startPending = 1'b0;
        remaining    = 0;
        forever begin
            @(negedge clk);
            if (startPending) begin
                modelBusy    = 1'b1;
                remaining    = FRAME;
                startPending = 1'b0;
            end else if (modelBusy) begin
                remaining--;
                if (remaining == 0) modelBusy = 1'b0;
            end
            if (selTxEn && !deadTx) startPending = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (selTxEn) begin
            checkOutput("sb_expected_pending", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                monEntry = expQ.pop_front();
                checkOutput("sb_tx_data", 32'(selTxData), 32'(monEntry.data));
                checkOutput("sb_grant", 32'(selGrant), 32'd1 << monEntry.idx);
                checkOutput("sb_ready", 32'(selReady), 32'd1 << monEntry.idx);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired: observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        forceBusy = 1'b0;
        deadTx    = 1'b0;
        useAlt    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_grant",   32'(selGrant),  32'd0);
        checkOutput("reset_tx_en",   32'(selTxEn),   32'd0);
        checkOutput("reset_tx_data", 32'(selTxData), 32'h00);
        checkOutput("reset_ready",   32'(selReady),  32'd0);
        checkOutput("reset_err",     32'(selErr),    32'd0);
        checkOutput("reset_active",  32'(selActive), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("drain_to_idle", 32'(selActive), 32'd0);

        // Single requester: one-cycle latency and a one-cycle ready pulse.
        @(posedge clk);
        applyStimulus(0, 8'h41, 1'b1);
        expectTx(2'd0, 8'h41);
        @(negedge clk);
        checkOutput("t1_no_early_en", 32'(selTxEn), 32'd0);
        @(negedge clk);
        checkOutput("t1_tx_en",   32'(selTxEn),   32'd1);
        checkOutput("t1_tx_data", 32'(selTxData), 32'h41);
        checkOutput("t1_ready",   32'(selReady),  32'b0001);
        @(negedge clk);
        checkOutput("t1_ready_pulse", 32'(selReady),  32'd0);
        checkOutput("t1_en_pulse",    32'(selTxEn),   32'd0);
        checkOutput("t1_data_stable", 32'(selTxData), 32'h41);
        waitQuiet("t1_done");
        checkOutput("t1_grant_released", 32'(selGrant), 32'd0);

        // Pointer now at 1: req1 beats req0 when both arrive together.
        @(posedge clk);
        applyStimulus(0, 8'h20, 1'b1);
        applyStimulus(1, 8'h21, 1'b1);
        expectTx(2'd1, 8'h21);
        expectTx(2'd0, 8'h20);
        waitQuiet("t2_done");

        // Contention from a reset pointer, with req0 coming back after req3.
        resetPulse();
        @(posedge clk);
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(0, 8'h14, 1'b1);
        applyStimulus(1, 8'h11, 1'b1);
        applyStimulus(2, 8'h12, 1'b1);
        applyStimulus(3, 8'h13, 1'b1);
        expectTx(2'd0, 8'h10);
        expectTx(2'd1, 8'h11);
        expectTx(2'd2, 8'h12);
        expectTx(2'd3, 8'h13);
        expectTx(2'd0, 8'h14);
        waitQuiet("t3_done");

        // Locked packet from req2 stays contiguous while req1 waits.
        @(posedge clk);
        applyStimulus(2, 8'hA0, 1'b0);
        applyStimulus(2, 8'hA1, 1'b0);
        applyStimulus(2, 8'hA2, 1'b1);
        expectTx(2'd2, 8'hA0);
        expectTx(2'd2, 8'hA1);
        expectTx(2'd2, 8'hA2);
        expectTx(2'd1, 8'h31);
        @(posedge clk);
        applyStimulus(1, 8'h31, 1'b1);
        waitQuiet("t4_done");

        // Lock timeout: grant drops 10 edges after the edge that first samples busy low.
        @(posedge clk);
        applyStimulus(3, 8'h51, 1'b0);
        expectTx(2'd3, 8'h51);
        waitN = 0;
        while (!txBusy && waitN < 50) begin
            @(posedge clk);
            waitN++;
        end
        checkOutput("t5_busy_rose", 32'(txBusy), 32'd1);
        waitN = 0;
        while (txBusy && waitN < 50) begin
            @(posedge clk);
            waitN++;
        end
        checkOutput("t5_busy_fell", 32'(txBusy), 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("t5_grant_held",  32'(selGrant),  32'b1000);
        checkOutput("t5_still_active", 32'(selActive), 32'd1);
        @(negedge clk);
        checkOutput("t5_grant_released", 32'(selGrant),  32'd0);
        checkOutput("t5_idle",           32'(selActive), 32'd0);
        checkOutput("t5_no_err",         32'(selErr),    32'd0);
        waitQuiet("t5_done");

        // Dead transmitter: err after BUSY_WAIT cycles, next request still served.
        deadTx = 1'b1;
        @(posedge clk);
        applyStimulus(0, 8'h61, 1'b1);
        expectTx(2'd0, 8'h61);
        waitTxEn("t6_tx_en");
        repeat (3) @(negedge clk);
        checkOutput("t6_err_not_yet", 32'(selErr), 32'd0);
        @(negedge clk);
        checkOutput("t6_err_set",      32'(selErr),    32'd1);
        checkOutput("t6_back_to_idle", 32'(selActive), 32'd0);
        checkOutput("t6_grant_clear",  32'(selGrant),  32'd0);
        deadTx = 1'b0;
        @(posedge clk);
        applyStimulus(1, 8'h62, 1'b1);
        expectTx(2'd1, 8'h62);
        waitQuiet("t6_done");
        checkOutput("t6_err_sticky", 32'(selErr), 32'd1);

        // Reset mid-frame: nothing issued until busy clears, then req0 first.
        @(posedge clk);
        applyStimulus(1, 8'h71, 1'b0);
        applyStimulus(1, 8'h72, 1'b1);
        expectTx(2'd1, 8'h71);
        waitTxEn("t7_first_en");
        @(negedge clk);
        forceBusy = 1'b1;
        rst       = 1'b1;
        applyStimulus(0, 8'h73, 1'b1);
        @(negedge clk);
        rst     = 1'b0;
        enCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (selTxEn) enCount++;
        end
        checkOutput("t7_no_en_while_busy", 32'(enCount),   32'd0);
        checkOutput("t7_draining",         32'(selActive), 32'd1);
        checkOutput("t7_err_cleared",      32'(selErr),    32'd0);
        expectTx(2'd0, 8'h73);
        expectTx(2'd1, 8'h72);
        forceBusy = 1'b0;
        waitQuiet("t7_done");

        // Without packet locking the two streams interleave byte by byte.
        @(negedge clk);
        rst    = 1'b1;
        useAlt = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        applyStimulus(2, 8'hB0, 1'b0);
        applyStimulus(2, 8'hB1, 1'b0);
        applyStimulus(2, 8'hB2, 1'b1);
        expectTx(2'd2, 8'hB0);
        expectTx(2'd1, 8'h81);
        expectTx(2'd2, 8'hB1);
        expectTx(2'd1, 8'h82);
        expectTx(2'd2, 8'hB2);
        @(posedge clk);
        applyStimulus(1, 8'h81, 1'b1);
        applyStimulus(1, 8'h82, 1'b1);
        waitQuiet("t8_done");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
